in_driver: RTL and testbench

- Memory-mapped input port: the read-side counterpart of the 16-bit output port driver on the CPU data bus.
- Samples 16 external pins through a 2-flop synchronizer and a per-bit debounce filter.
- Records rising and falling changes in sticky read-to-clear flags and returns either register on a 32-bit read bus.
- Raises a level interrupt while any enabled change flag is pending.

---
 rtl/in_driver_pkg.sv | 11 +
 rtl/in_debounce.sv | 45 ++++
 rtl/in_driver.sv | 105 ++++++++++
 tb/tb_in_driver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/in_driver_pkg.sv
// Shared constants and types for the in_driver memory-mapped input port.
package in_driver_pkg;
    localparam int PORT_W = 16;

    typedef logic [PORT_W-1:0] port_t;

    localparam logic [31:0] DATA_ADDR = 32'd12;
    localparam logic [31:0] FLAG_ADDR = 32'd16;
    localparam logic [31:0] MASK_ADDR = 32'd20;
    localparam logic [31:0] EDGE_ADDR = 32'd24;
endpackage

// File: rtl/in_debounce.sv
// Single-bit debounce filter: the state follows sync_in only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles. changed pulses on the flip cycle.
module in_debounce
    import in_driver_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic state_out,
    output logic changed
);
    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       state_q, state_d;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        changed = 1'b0;
        if (sync_in == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            state_d = ~state_q;
            cnt_d   = '0;
            changed = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state_out = state_q;
endmodule

// File: rtl/in_driver.sv
// Memory-mapped 16-bit debounced input port with sticky change flags and masked irq.
// Define IN_DRIVER_EDGE_SELECT_EN to add the per-bit edge-select register at EDGE_ADDR.
module in_driver
    import in_driver_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IO_pins,
    input  logic [31:0] adress,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] bus_in,
    output logic [31:0] bus_out,
    output logic        irq
);
    port_t       sync1_q, sync1_d;
    port_t       sync2_q, sync2_d;
    port_t       flags_q, flags_d;
    port_t       mask_q, mask_d;
    port_t       state, changed, flag_set, flag_clr;
    logic [31:0] bus_q, bus_d;
    logic        irq_q, irq_d;
    logic        unused_bus_hi;

`ifdef IN_DRIVER_EDGE_SELECT_EN
    port_t       edge_q, edge_d;
`endif

    assign unused_bus_hi = &{1'b0, bus_in[31:16]};

    for (genvar i = 0; i < PORT_W; i++) begin : g_deb
        in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .reset    (reset),
            .sync_in  (sync2_q[i]),
            .state_out(state[i]),
            .changed  (changed[i])
        );
    end

    always_comb begin
        sync1_d = IO_pins;
        sync2_d = sync1_q;

`ifdef IN_DRIVER_EDGE_SELECT_EN
        // Pre-flip state 0 means a rising change; edge_sel picks which direction flags.
        flag_set = changed & ~(state ^ edge_q);
        edge_d   = (wr_en && adress == EDGE_ADDR) ? bus_in[15:0] : edge_q;
`else
        flag_set = changed;
`endif

        // Clear only what this read returns; a same-cycle set survives.
        flag_clr = (rd_en && adress == FLAG_ADDR) ? flags_q : '0;
        flags_d  = (flags_q & ~flag_clr) | flag_set;

        mask_d = (wr_en && adress == MASK_ADDR) ? bus_in[15:0] : mask_q;

        bus_d = bus_q;
        if (rd_en) begin
            case (adress)
                DATA_ADDR: bus_d = {16'h0, state};
                FLAG_ADDR: bus_d = {16'h0, flags_q};
                MASK_ADDR: bus_d = {16'h0, mask_q};
`ifdef IN_DRIVER_EDGE_SELECT_EN
                EDGE_ADDR: bus_d = {16'h0, edge_q};
`endif
                default:   bus_d = 32'h0;
            endcase
        end

        irq_d = |(flags_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            flags_q <= '0;
            mask_q  <= '0;
            bus_q   <= '0;
            irq_q   <= 1'b0;
`ifdef IN_DRIVER_EDGE_SELECT_EN
            edge_q  <= '0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            flags_q <= flags_d;
            mask_q  <= mask_d;
            bus_q   <= bus_d;
            irq_q   <= irq_d;
`ifdef IN_DRIVER_EDGE_SELECT_EN
            edge_q  <= edge_d;
`endif
        end
    end

    assign bus_out = bus_q;
    assign irq     = irq_q;
endmodule

// File: tb/tb_in_driver.sv
// Self-checking bench for in_driver: directed scenarios plus randomized traffic
// against a sample-history reference model.
module tb_in_driver;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] IO_pins = '0;
    logic [31:0] adress = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] bus_in = '0;
    logic [31:0] bus_out;
    logic        irq;

    int n_checks = 0;
    int n_pass = 0;

    in_driver #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk    (clk),
        .reset  (reset),
        .IO_pins(IO_pins),
        .adress (adress),
        .rd_en  (rd_en),
        .wr_en  (wr_en),
        .bus_in (bus_in),
        .bus_out(bus_out),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a bit's state flips once the last DEB synchronized
    // samples all disagree with it.
    logic [15:0] m_s1, m_sync, m_state, m_flags, m_mask, m_edge;
    logic [15:0] m_hist [DEB];
    int          m_nv;
    logic [31:0] m_bus, m_bus_d;
    logic        m_irq;
    logic [15:0] m_flip, m_set, m_clr;

    always_comb begin
        m_flip = (m_nv >= DEB - 1) ? (m_sync ^ m_state) : 16'h0;
        for (int k = 0; k < DEB - 1; k++) m_flip = m_flip & (m_hist[k] ^ m_state);
`ifdef IN_DRIVER_EDGE_SELECT_EN
        m_set = m_flip & ~(m_state ^ m_edge);
`else
        m_set = m_flip;
`endif
        m_clr = (rd_en && adress == 32'd16) ? m_flags : 16'h0;
        m_bus_d = m_bus;
        if (rd_en) begin
            if (adress == 32'd12) m_bus_d = {16'h0, m_state};
            else if (adress == 32'd16) m_bus_d = {16'h0, m_flags};
            else if (adress == 32'd20) m_bus_d = {16'h0, m_mask};
`ifdef IN_DRIVER_EDGE_SELECT_EN
            else if (adress == 32'd24) m_bus_d = {16'h0, m_edge};
`endif
            else m_bus_d = 32'h0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1 <= '0; m_sync <= '0; m_state <= '0; m_flags <= '0;
            m_mask <= '0; m_edge <= '0; m_bus <= '0; m_irq <= 1'b0; m_nv <= 0;
            for (int k = 0; k < DEB; k++) m_hist[k] <= '0;
        end else begin
            m_s1    <= IO_pins;
            m_sync  <= m_s1;
            m_hist[0] <= m_sync;
            for (int k = 1; k < DEB; k++) m_hist[k] <= m_hist[k-1];
            m_nv    <= (m_nv < DEB) ? m_nv + 1 : DEB;
            m_state <= m_state ^ m_flip;
            m_flags <= (m_flags & ~m_clr) | m_set;
            if (wr_en && adress == 32'd20) m_mask <= bus_in[15:0];
            if (wr_en && adress == 32'd24) m_edge <= bus_in[15:0];
            m_bus   <= m_bus_d;
            m_irq   <= |(m_flags & m_mask);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        tick(1);
        reset = 1'b0; IO_pins = '0; rd_en = 1'b0; wr_en = 1'b0; adress = '0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] v);
        adress = a; rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0; adress = '0;
        v = bus_out;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        adress = a; bus_in = d; wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0; adress = '0; bus_in = '0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            IO_pins = 16'($urandom);
            tick(1);
            n_checks++;
            if (bus_out !== 32'h0) $display("[TB] FAIL reset_bus: got %h want 0", bus_out);
            else n_pass++;
            n_checks++;
            if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b want 0", irq);
            else n_pass++;
        end
        IO_pins = '0;
        reset = 1'b1;
        do_read(32'd12, v);
        n_checks++;
        if (v !== 32'h0) $display("[TB] FAIL reset_data: got %h want 0", v);
        else n_pass++;
    endtask

    task automatic test_clean_step();
        logic [31:0] v;
        reset_dut();
        IO_pins = 16'hA5A5;
        tick(5);
        do_read(32'd12, v);
        n_checks++;
        if (v !== 32'h0) $display("[TB] FAIL step_early: got %h want 0", v);
        else n_pass++;
        do_read(32'd12, v);
        n_checks++;
        if (v !== 32'h0000A5A5) $display("[TB] FAIL step_data: got %h want 0000a5a5", v);
        else n_pass++;
        do_read(32'd16, v);
        n_checks++;
        if (v !== 32'h0000A5A5) $display("[TB] FAIL step_flags: got %h want 0000a5a5", v);
        else n_pass++;
        do_read(32'd16, v);
        n_checks++;
        if (v !== 32'h0) $display("[TB] FAIL step_flags_clr: got %h want 0", v);
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        reset_dut();
        IO_pins = 16'h0008;
        tick(DEB - 1);
        IO_pins = 16'h0000;
        tick(8);
        do_read(32'd12, v);
        n_checks++;
        if (v !== 32'h0) $display("[TB] FAIL glitch_data: got %h want 0", v);
        else n_pass++;
        do_read(32'd16, v);
        n_checks++;
        if (v !== 32'h0) $display("[TB] FAIL glitch_flags: got %h want 0", v);
        else n_pass++;
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        reset_dut();
        do_write(32'd20, 32'h0000_0008);
        IO_pins = 16'h0008;
        tick(2 + DEB);
        n_checks++;
        if (irq !== 1'b0) $display("[TB] FAIL irq_early: got %b want 0", irq);
        else n_pass++;
        tick(1);
        n_checks++;
        if (irq !== 1'b1) $display("[TB] FAIL irq_set: got %b want 1", irq);
        else n_pass++;
        do_read(32'd16, v);
        n_checks++;
        if (v !== 32'h8) $display("[TB] FAIL irq_flags: got %h want 00000008", v);
        else n_pass++;
        tick(1);
        n_checks++;
        if (irq !== 1'b0) $display("[TB] FAIL irq_clear: got %b want 0", irq);
        else n_pass++;
        IO_pins = 16'h0018;
        tick(8);
        n_checks++;
        if (irq !== 1'b0) $display("[TB] FAIL irq_masked: got %b want 0", irq);
        else n_pass++;
        do_read(32'd16, v);
        n_checks++;
        if (v !== 32'h10) $display("[TB] FAIL irq_masked_flag: got %h want 00000010", v);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [31:0] v;
        reset_dut();
        IO_pins = 16'h0001;
        tick(1 + DEB);
        do_read(32'd16, v);
        n_checks++;
        if (v !== 32'h0) $display("[TB] FAIL collide_first: got %h want 0", v);
        else n_pass++;
        do_read(32'd16, v);
        n_checks++;
        if (v !== 32'h1) $display("[TB] FAIL collide_second: got %h want 00000001", v);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        reset_dut();
        do_write(32'd20, 32'h0000_FFFF);
        do_read(32'd20, v);
        n_checks++;
        if (v !== 32'h0000FFFF) $display("[TB] FAIL mask_readback: got %h want 0000ffff", v);
        else n_pass++;
        IO_pins = 16'hFFFF;
        tick(4);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus_out !== 32'h0) $display("[TB] FAIL async_bus: got %h want 0", bus_out);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("[TB] FAIL async_irq: got %b want 0", irq);
        else n_pass++;
        tick(1);
        reset = 1'b1;
        tick(DEB + 1);
        do_read(32'd16, v);
        n_checks++;
        if (v !== 32'h0) $display("[TB] FAIL async_no_early_flag: got %h want 0", v);
        else n_pass++;
        do_read(32'd16, v);
        n_checks++;
        if (v !== 32'h0000FFFF) $display("[TB] FAIL async_flag_after: got %h want 0000ffff", v);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] addrs [6];
        int hold;
        addrs[0] = 32'd12; addrs[1] = 32'd16; addrs[2] = 32'd20;
        addrs[3] = 32'd24; addrs[4] = 32'd0;  addrs[5] = 32'd8;
        reset_dut();
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                IO_pins = IO_pins ^ 16'($urandom & $urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            rd_en  = ($urandom_range(0, 2) == 0);
            wr_en  = ($urandom_range(0, 5) == 0);
            adress = addrs[$urandom_range(0, 5)];
            bus_in = $urandom;
            tick(1);
            n_checks++;
            if (bus_out !== m_bus) $display("[TB] FAIL rand_bus cycle %0d: got %h want %h", i, bus_out, m_bus);
            else n_pass++;
            n_checks++;
            if (irq !== m_irq) $display("[TB] FAIL rand_irq cycle %0d: got %b want %b", i, irq, m_irq);
            else n_pass++;
        end
        rd_en = 1'b0; wr_en = 1'b0; adress = '0;
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_interrupt();
        test_collision();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
